// File: rtl/mul_add8.sv
// mul_add8: sequential 8-bit multiply-accumulate, P = A*B + C, using a fixed
// 8-step shift-and-add sequence under a start/busy/done handshake.
module mul_add8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [7:0]  C,
  output logic        busy,
  output logic        done,
  output logic [15:0] P
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [15:0] mcand, mcand_n;
  logic [7:0]  mplier, mplier_n;
  logic [15:0] acc, acc_n;
  logic [2:0]  cnt, cnt_n;
  logic [15:0] p_r, p_n;
  logic        busy_r, done_r;
  logic [15:0] acc_step;

  // Add-if-LSB step; the maximum result 16'hFF00 fits, so no carry is kept.
  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  always_comb begin
    state_n  = state;
    mcand_n  = mcand;
    mplier_n = mplier;
    acc_n    = acc;
    cnt_n    = cnt;
    p_n      = p_r;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          mcand_n  = {8'h00, A};
          mplier_n = B;
          acc_n    = {8'h00, C};
          cnt_n    = '0;
          state_n  = RUN;
        end else begin
          state_n  = IDLE;
        end
      end
      RUN: begin
        acc_n    = acc_step;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + 3'd1;
        if (cnt == 3'd7) begin
          p_n     = acc_step;
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // busy/done are flopped from the next state so they are true register outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      p_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      p_r    <= p_n;
      busy_r <= (state_n == RUN);
      done_r <= (state_n == DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign P    = p_r;

endmodule

// File: tb/tb_mul_add8.sv
// Directed self-checking bench for mul_add8: handshake timing, corner operands,
// back-to-back operation, ignored restarts and mid-operation reset.
module tb_mul_add8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  A, B, C;
  logic        busy, done;
  logic [15:0] P;

  int total = 0;
  int bad   = 0;

  mul_add8 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .C    (C),
    .busy (busy),
    .done (done),
    .P    (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = '0; B = '0; C = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, P} !== {1'b0, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b P=%h required 0 0 0000", busy, done, P);
    end
    // rst and start together: reset wins
    start = 1'b1; A = 8'd5; B = 8'd5; C = 8'd5;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_beats_start: busy=%b required 0", busy);
    end
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    start = 1'b1; A = 8'd13; B = 8'd11; C = 8'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({busy, done, P} !== {1'b1, 1'b0, 16'h0000}) begin
        bad++;
        $display("FAIL basic_run[%0d]: busy=%b done=%b P=%h required 1 0 0000", i, busy, done, P);
      end
      @(negedge clk);
    end
    total++;
    if ({busy, done, P} !== {1'b0, 1'b1, 16'h0094}) begin
      bad++;
      $display("FAIL basic_done: busy=%b done=%b P=%h required 0 1 0094", busy, done, P);
    end
    @(negedge clk);
    total++;
    if ({busy, done, P} !== {1'b0, 1'b0, 16'h0094}) begin
      bad++;
      $display("FAIL basic_after: busy=%b done=%b P=%h required 0 0 0094", busy, done, P);
    end
  endtask

  task automatic test_corner();
    logic [7:0]  ta [3] = '{8'd255, 8'd0,   8'd9};
    logic [7:0]  tb [3] = '{8'd255, 8'd200, 8'd0};
    logic [7:0]  tc [3] = '{8'd255, 8'd77,  8'd0};
    logic [15:0] te [3] = '{16'hFF00, 16'd77, 16'd0};
    logic [15:0] prev;
    prev = 16'h0094;
    for (int t = 0; t < 3; t++) begin
      start = 1'b1; A = ta[t]; B = tb[t]; C = tc[t];
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
        total++;
        if ({busy, done, P} !== {1'b1, 1'b0, prev}) begin
          bad++;
          $display("FAIL corner%0d_run[%0d]: busy=%b done=%b P=%h required 1 0 %h", t, i, busy, done, P, prev);
        end
        @(negedge clk);
      end
      total++;
      if ({busy, done, P} !== {1'b0, 1'b1, te[t]}) begin
        bad++;
        $display("FAIL corner%0d_done: busy=%b done=%b P=%h required 0 1 %h", t, busy, done, P, te[t]);
      end
      prev = te[t];
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; A = 8'd3; B = 8'd4; C = 8'd1;
    @(negedge clk);
    A = 8'd6; B = 8'd7; C = 8'd2;   // start stays high
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({busy, done, P} !== {1'b1, 1'b0, 16'd0}) begin
        bad++;
        $display("FAIL b2b_first_run[%0d]: busy=%b done=%b P=%h required 1 0 0000", i, busy, done, P);
      end
      @(negedge clk);
    end
    total++;
    if ({busy, done, P} !== {1'b0, 1'b1, 16'd13}) begin
      bad++;
      $display("FAIL b2b_first_done: busy=%b done=%b P=%h required 0 1 000d", busy, done, P);
    end
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({busy, done, P} !== {1'b1, 1'b0, 16'd13}) begin
        bad++;
        $display("FAIL b2b_second_run[%0d]: busy=%b done=%b P=%h required 1 0 000d", i, busy, done, P);
      end
      @(negedge clk);
    end
    total++;
    if ({busy, done, P} !== {1'b0, 1'b1, 16'd44}) begin
      bad++;
      $display("FAIL b2b_second_done: busy=%b done=%b P=%h required 0 1 002c", busy, done, P);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_restart();
    start = 1'b1; A = 8'd10; B = 8'd10; C = 8'd10;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        start = 1'b1; A = 8'd1; B = 8'd1; C = 8'd1;
      end else begin
        start = 1'b0;
      end
      total++;
      if ({busy, done} !== 2'b10) begin
        bad++;
        $display("FAIL ignore_run[%0d]: busy=%b done=%b required 1 0", i, busy, done);
      end
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if ({busy, done, P} !== {1'b0, 1'b1, 16'd110}) begin
      bad++;
      $display("FAIL ignore_done: busy=%b done=%b P=%h required 0 1 006e", busy, done, P);
    end
    @(negedge clk);
    total++;
    if ({busy, done, P} !== {1'b0, 1'b0, 16'd110}) begin
      bad++;
      $display("FAIL ignore_idle: busy=%b done=%b P=%h required 0 0 006e", busy, done, P);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    start = 1'b1; A = 8'd50; B = 8'd3; C = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, done, P} !== {1'b0, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL midrst_state: busy=%b done=%b P=%h required 0 0 0000", busy, done, P);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL midrst_no_done: activity_cycles=%0d required 0", pulses);
    end
    start = 1'b1; A = 8'd2; B = 8'd2; C = 8'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if ({busy, done, P} !== {1'b0, 1'b1, 16'd4}) begin
      bad++;
      $display("FAIL midrst_restart: busy=%b done=%b P=%h required 0 1 0004", busy, done, P);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_corner();
    test_back_to_back();
    test_ignore_restart();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
